// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the round-robin packet bus arbiter.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        POP   = 2'd1,
        ROUTE = 2'd2,
        PUSH  = 2'd3
    } arb_state_t;

    localparam int DEST_W    = 8;
    // Widest packet the helpers accept; callers zero-extend into this width.
    localparam int MAX_PKT_W = 256;

    function automatic logic [DEST_W-1:0] dest_of(input logic [MAX_PKT_W-1:0] pkt,
                                                  input int                   pkt_w);
        logic [MAX_PKT_W-1:0] shifted;
        shifted = pkt >> (pkt_w - DEST_W);
        return shifted[DEST_W-1:0];
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] cnt);
        return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational rotating-priority encoder: first set request at or above ptr, wrapping.
module rr_picker #(
    parameter int drvrs = 4,
    parameter int PW    = $clog2(drvrs)
) (
    input  logic [drvrs-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [PW-1:0]    grant,
    output logic             any
);

    logic [PW-1:0] cand;

    always_comb begin
        grant = '0;
        any   = 1'b0;
        cand  = '0;
        for (int i = 0; i < drvrs; i++) begin
            cand = PW'((int'(ptr) + i) % drvrs);
            if (!any && req[cand]) begin
                any   = 1'b1;
                grant = cand;
            end
        end
    end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter/router for the multi-driver packet bus with receiver backpressure.
// Define BUS_ARB_TIMEOUT_EN to drop packets whose receivers stay busy for `timeout` cycles.
module bus_rr_arbiter
    import bus_arb_pkg::*;
#(
    parameter int          drvrs     = 4,
    parameter int          pckg_sz   = 16,
    parameter logic [7:0]  broadcast = 8'hFF,
    parameter int          timeout   = 64
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [drvrs-1:0]                pndng,
    input  logic [drvrs-1:0][pckg_sz-1:0]   D_pop,
    output logic [drvrs-1:0]                pop,
    input  logic [drvrs-1:0]                rdy,
    output logic [drvrs-1:0]                push,
    output logic [pckg_sz-1:0]              D_push,
    output logic [15:0]                     err_cnt,
    output logic [15:0]                     drop_cnt
);

    localparam int PW = $clog2(drvrs);
`ifdef BUS_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    localparam logic [31:0] TO_LAST = 32'(timeout - 1);

    arb_state_t           state_q, state_d;
    logic [PW-1:0]        ptr_q, ptr_d;
    logic [PW-1:0]        grant_q, grant_d;
    logic [pckg_sz-1:0]   pkt_q, pkt_d;
    logic [drvrs-1:0]     mask_q, mask_d;
    logic [drvrs-1:0]     pop_q, pop_d;
    logic [drvrs-1:0]     push_q, push_d;
    logic [pckg_sz-1:0]   dpush_q, dpush_d;
    logic [15:0]          err_cnt_q, err_cnt_d;
    logic [15:0]          drop_cnt_q, drop_cnt_d;
    logic                 err_pend_q, err_pend_d;
    logic [31:0]          tcnt_q, tcnt_d;

    logic [PW-1:0]        pick_grant;
    logic                 pick_any;
    logic [drvrs-1:0]     pick_onehot;
    logic [drvrs-1:0]     bcast_mask;
    logic [drvrs-1:0]     ucast_mask;
    logic [DEST_W-1:0]    dest;
    logic [PW-1:0]        next_ptr;

    rr_picker #(
        .drvrs (drvrs),
        .PW    (PW)
    ) u_picker (
        .req   (pndng),
        .ptr   (ptr_q),
        .grant (pick_grant),
        .any   (pick_any)
    );

    assign dest     = dest_of(MAX_PKT_W'(D_pop[grant_q]), pckg_sz);
    assign next_ptr = (int'(grant_q) == drvrs - 1) ? '0 : grant_q + 1'b1;

    for (genvar gi = 0; gi < drvrs; gi++) begin : g_masks
        assign pick_onehot[gi] = (int'(pick_grant) == gi);
        assign bcast_mask[gi]  = (int'(grant_q) != gi);
        assign ucast_mask[gi]  = (int'(dest) == gi);
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_d    = grant_q;
        pkt_d      = pkt_q;
        mask_d     = mask_q;
        pop_d      = '0;
        push_d     = '0;
        dpush_d    = '0;
        err_pend_d = 1'b0;
        tcnt_d     = tcnt_q;
        drop_cnt_d = drop_cnt_q;
        // Error accounting lags the POP decision by one edge.
        err_cnt_d  = err_pend_q ? sat_inc16(err_cnt_q) : err_cnt_q;

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d = pick_grant;
                    pop_d   = pick_onehot;
                    state_d = POP;
                end
            end
            POP: begin
                pkt_d = D_pop[grant_q];
                if (dest == broadcast) begin
                    mask_d  = bcast_mask;
                    state_d = ROUTE;
                end else if (int'(dest) < drvrs && int'(dest) != int'(grant_q)) begin
                    mask_d  = ucast_mask;
                    state_d = ROUTE;
                end else begin
                    err_pend_d = 1'b1;
                    ptr_d      = next_ptr;
                    state_d    = IDLE;
                end
            end
            ROUTE: begin
                if ((rdy & mask_q) == mask_q) begin
                    push_d  = mask_q;
                    dpush_d = pkt_q;
                    tcnt_d  = '0;
                    state_d = PUSH;
                end else if (TO_EN && tcnt_q == TO_LAST) begin
                    drop_cnt_d = sat_inc16(drop_cnt_q);
                    tcnt_d     = '0;
                    ptr_d      = next_ptr;
                    state_d    = IDLE;
                end else if (TO_EN) begin
                    tcnt_d = tcnt_q + 32'd1;
                end
            end
            PUSH: begin
                ptr_d   = next_ptr;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            grant_q    <= '0;
            pkt_q      <= '0;
            mask_q     <= '0;
            pop_q      <= '0;
            push_q     <= '0;
            dpush_q    <= '0;
            err_cnt_q  <= '0;
            drop_cnt_q <= '0;
            err_pend_q <= 1'b0;
            tcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_q    <= grant_d;
            pkt_q      <= pkt_d;
            mask_q     <= mask_d;
            pop_q      <= pop_d;
            push_q     <= push_d;
            dpush_q    <= dpush_d;
            err_cnt_q  <= err_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            err_pend_q <= err_pend_d;
            tcnt_q     <= tcnt_d;
        end
    end

    assign pop      = pop_q;
    assign push     = push_q;
    assign D_push   = dpush_q;
    assign err_cnt  = err_cnt_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Randomized bench for bus_rr_arbiter against a packet-lifecycle timeline model.
module tb_bus_rr_arbiter;

    localparam int N       = 4;
    localparam int W       = 16;
    localparam int TIMEOUT = 64;
`ifdef BUS_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic               clk   = 1'b0;
    logic               reset = 1'b1;
    logic [N-1:0]       pndng = '0;
    logic [N-1:0]       rdy   = '1;
    logic [N-1:0][W-1:0] d_pop = '0;
    logic [N-1:0]       pop;
    logic [N-1:0]       push;
    logic [W-1:0]       d_push;
    logic [15:0]        err_cnt;
    logic [15:0]        drop_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bus_rr_arbiter #(
        .drvrs     (N),
        .pckg_sz   (W),
        .broadcast (8'hFF),
        .timeout   (TIMEOUT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .pndng    (pndng),
        .D_pop    (d_pop),
        .pop      (pop),
        .rdy      (rdy),
        .push     (push),
        .D_push   (d_push),
        .err_cnt  (err_cnt),
        .drop_cnt (drop_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Device FIFOs (show-ahead), one ring per device
    logic [W-1:0] mem [N][64];
    int           wr [N] = '{default: 0};
    int           rd [N] = '{default: 0};
    logic [N-1:0] rm_mask = '0;

    task automatic enq(input int d, input logic [W-1:0] v);
        mem[d][wr[d] % 64] = v;
        wr[d]++;
    endtask

    always @(posedge clk) begin
        #1;
        for (int d = 0; d < N; d++)
            if (rm_mask[d] && rd[d] != wr[d]) rd[d]++;
        #1;
        for (int d = 0; d < N; d++) begin
            pndng[d] = (rd[d] != wr[d]);
            d_pop[d] = pndng[d] ? mem[d][rd[d] % 64] : '0;
        end
    end

    // Timeline model: what each edge must produce, from the packet rules
    int           cyc = 0;
    bit           started = 1'b0;
    bit           waiting = 1'b0;
    int           free_at = 0;
    int           route_from = 0;
    int           err_due = -1;
    int           m_ptr = 0;
    int           m_g = 0;
    logic [N-1:0] m_pop = '0, m_push = '0, m_mask = '0;
    logic [W-1:0] m_dpush = '0, m_pkt = '0;
    logic [15:0]  m_err = '0, m_drop = '0;

    always @(posedge clk) begin
        int  cand;
        int  dst;
        bit  found;
        cyc++;
        rm_mask = m_pop;
        m_pop   = '0;
        m_push  = '0;
        m_dpush = '0;
        if (reset) begin
            started = 1'b1;
            waiting = 1'b0;
            free_at = cyc + 1;
            err_due = -1;
            m_ptr   = 0;
            m_err   = '0;
            m_drop  = '0;
        end else begin
            if (err_due == cyc) begin
                if (m_err != 16'hFFFF) m_err = m_err + 16'd1;
                err_due = -1;
            end
            if (waiting && cyc >= route_from) begin
                if ((rdy & m_mask) == m_mask) begin
                    m_push  = m_mask;
                    m_dpush = m_pkt;
                    m_ptr   = (m_g + 1) % N;
                    free_at = cyc + 2;
                    waiting = 1'b0;
                end else if (TO_EN && (cyc - route_from + 1) == TIMEOUT) begin
                    if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
                    m_ptr   = (m_g + 1) % N;
                    free_at = cyc + 1;
                    waiting = 1'b0;
                end
            end else if (!waiting && cyc >= free_at && pndng != '0) begin
                found = 1'b0;
                for (int i = 0; i < N; i++) begin
                    cand = (m_ptr + i) % N;
                    if (!found && pndng[cand]) begin
                        found = 1'b1;
                        m_g   = cand;
                    end
                end
                m_pop[m_g] = 1'b1;
                m_pkt = d_pop[m_g];
                dst   = int'(m_pkt >> (W - 8));
                if (dst == 255) begin
                    m_mask = '1;
                    m_mask[m_g] = 1'b0;
                    waiting = 1'b1;
                    route_from = cyc + 2;
                end else if (dst < N && dst != m_g) begin
                    m_mask = '0;
                    m_mask[dst] = 1'b1;
                    waiting = 1'b1;
                    route_from = cyc + 2;
                end else begin
                    err_due = cyc + 2;
                    m_ptr   = (m_g + 1) % N;
                    free_at = cyc + 2;
                end
            end
        end
    end

    // Compare process and event log
    int           mcyc = 0;
    int           pop_dev_q[$];
    int           pop_cyc_q[$];
    logic [N-1:0] push_mask_q[$];
    logic [W-1:0] push_data_q[$];

    always @(negedge clk) begin
        mcyc++;
        if (started) begin
            chk("pop", 32'(pop), 32'(m_pop));
            chk("push", 32'(push), 32'(m_push));
            if (m_push != '0) chk("d_push", 32'(d_push), 32'(m_dpush));
            chk("err_cnt", 32'(err_cnt), 32'(m_err));
            chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        end
        if (pop != '0) begin
            for (int d = 0; d < N; d++)
                if (pop[d]) begin
                    pop_dev_q.push_back(d);
                    pop_cyc_q.push_back(mcyc);
                end
        end
        if (push != '0) begin
            push_mask_q.push_back(push);
            push_data_q.push_back(d_push);
            $display("txn: cycle %0d push=%b data=%h err_cnt=%0d drop_cnt=%0d",
                     mcyc, push, d_push, err_cnt, drop_cnt);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
    endtask

    function automatic logic [W-1:0] rand_pkt();
        int          r;
        logic [7:0]  dst;
        r = $urandom_range(19);
        if (r < 12)      dst = 8'($urandom_range(N - 1));
        else if (r < 15) dst = 8'hFF;
        else             dst = 8'($urandom_range(255));
        return {dst, 8'($urandom)};
    endfunction

    initial begin
        int np, nu;
        tick(3);
        reset = 1'b0;
        chk("rst_pop", 32'(pop), 32'h0);
        chk("rst_push", 32'(push), 32'h0);
        chk("rst_dpush", 32'(d_push), 32'h0);
        chk("rst_err", 32'(err_cnt), 32'h0);
        chk("rst_drop", 32'(drop_cnt), 32'h0);

        // single unicast
        np = pop_dev_q.size(); nu = push_mask_q.size();
        enq(1, 16'h0203);
        tick(8);
        chk("uni_npop", 32'(pop_dev_q.size() - np), 32'd1);
        chk("uni_popdev", 32'(pop_dev_q[np]), 32'd1);
        chk("uni_npush", 32'(push_mask_q.size() - nu), 32'd1);
        chk("uni_mask", 32'(push_mask_q[nu]), 32'h4);
        chk("uni_data", 32'(push_data_q[nu]), 32'h0203);

        // round robin from ptr 0, then wrap
        do_reset();
        np = pop_dev_q.size();
        for (int d = 0; d < N; d++) enq(d, {8'((d + 1) % N), 8'(d)});
        tick(24);
        for (int i = 0; i < N; i++) chk("rr_order", 32'(pop_dev_q[np + i]), 32'(i));
        for (int i = 1; i < N; i++)
            chk("rr_spacing", 32'(pop_cyc_q[np + i] - pop_cyc_q[np + i - 1]), 32'd4);
        enq(3, 16'h0177);
        enq(0, 16'h0188);
        tick(12);
        chk("rr_wrap0", 32'(pop_dev_q[np + 4]), 32'd0);
        chk("rr_wrap1", 32'(pop_dev_q[np + 5]), 32'd3);

        // broadcast
        nu = push_mask_q.size();
        enq(2, 16'hFF55);
        tick(8);
        chk("bc_npush", 32'(push_mask_q.size() - nu), 32'd1);
        chk("bc_mask", 32'(push_mask_q[nu]), 32'hB);
        chk("bc_data", 32'(push_data_q[nu]), 32'hFF55);

        // invalid destinations
        do_reset();
        np = pop_dev_q.size(); nu = push_mask_q.size();
        enq(0, 16'h0711);
        enq(0, 16'h0022);
        tick(12);
        chk("inv_npop", 32'(pop_dev_q.size() - np), 32'd2);
        chk("inv_npush", 32'(push_mask_q.size() - nu), 32'd0);
        chk("inv_err", 32'(err_cnt), 32'd2);
        chk("inv_model_err", 32'(m_err), 32'd2);

        // backpressure on device 3
        nu = push_mask_q.size();
        rdy = 4'b0111;
        enq(0, 16'h0333);
        tick(100);
        chk("bp_stall", 32'(push_mask_q.size() - nu), 32'd0);
`ifdef BUS_ARB_TIMEOUT_EN
        chk("to_drop", 32'(drop_cnt), 32'd1);
        chk("to_model_drop", 32'(m_drop), 32'd1);
        rdy = '1;
        tick(3);
        chk("to_nopush", 32'(push_mask_q.size() - nu), 32'd0);
`else
        rdy = '1;
        tick(3);
        chk("bp_npush", 32'(push_mask_q.size() - nu), 32'd1);
        chk("bp_mask", 32'(push_mask_q[nu]), 32'h8);
        chk("bp_data", 32'(push_data_q[nu]), 32'h0333);
`endif

        // reset while waiting in ROUTE
        rdy = 4'b0111;
        enq(0, 16'h0344);
        tick(6);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("mid_pop", 32'(pop), 32'h0);
        chk("mid_push", 32'(push), 32'h0);
        chk("mid_dpush", 32'(d_push), 32'h0);
        chk("mid_err", 32'(err_cnt), 32'h0);
        chk("mid_drop", 32'(drop_cnt), 32'h0);
        rdy = '1;
        np = pop_dev_q.size(); nu = push_mask_q.size();
        enq(2, 16'h0155);
        tick(8);
        chk("mid_popdev", 32'(pop_dev_q[np]), 32'd2);
        chk("mid_mask", 32'(push_mask_q[nu]), 32'h2);

        // randomized traffic, backpressure and occasional reset
        for (int c = 0; c < 900; c++) begin
            for (int d = 0; d < N; d++)
                if ((wr[d] - rd[d]) < 3 && $urandom_range(5) == 0) enq(d, rand_pkt());
            for (int d = 0; d < N; d++) rdy[d] = ($urandom_range(9) < 8);
            if (c >= 300 && c < 400) rdy[3] = 1'b0;
            reset = ($urandom_range(299) == 0);
            tick(1);
        end
        reset = 1'b0;
        rdy   = '1;
        tick(40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
